// File: rtl/rf_multi.sv
// rf_multi: dual-read, single-write register file with a hardware clear
// sequence after reset. Entry 0 can be hardwired to zero (ZERO_REG).
// Optional feature macro: RF_BYPASS_EN -- write-through forwarding of wd to a
// read port whose address matches the in-flight write address.
module rf_multi #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w,
  input  logic [ADDR_W-1:0] wn,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic              ZERO_EN  = (ZERO_REG != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;

  logic              user_we_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [WIDTH-1:0]  mem_wdata_c;

  logic [WIDTH-1:0]  mem_q [DEPTH];

  // Control registers: synchronous reset restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // User write qualifies only in READY, outside reset, and never to a hardwired entry 0.
  always_comb begin
    user_we_c = 1'b0;
    if ((state_q == ST_READY) && w && !reset) begin
      user_we_c = !(ZERO_EN && (wn == '0));
    end
  end

  // Next-state logic and memory write port selection.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    busy_d      = busy_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = wn;
    mem_wdata_c = wd;

    unique case (state_q)
      ST_CLEAR: begin
        // Reset cycle itself writes nothing; zeroing happens only in clear cycles.
        mem_we_c    = !reset;
        mem_waddr_c = clr_cnt_q;
        mem_wdata_c = '0;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        mem_we_c = user_we_c;
      end
      default: begin
        state_d = ST_CLEAR;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Storage array: no reset, contents are zeroed by the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Read port 1: combinational, zero while clearing or when addressing a hardwired entry 0.
  always_comb begin
    rd1 = mem_q[rs1];
    if ((state_q == ST_CLEAR) || (ZERO_EN && (rs1 == '0))) begin
      rd1 = '0;
    end
`ifdef RF_BYPASS_EN
    else if (user_we_c && (wn == rs1)) begin
      rd1 = wd;
    end
`endif
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = mem_q[rs2];
    if ((state_q == ST_CLEAR) || (ZERO_EN && (rs2 == '0))) begin
      rd2 = '0;
    end
`ifdef RF_BYPASS_EN
    else if (user_we_c && (wn == rs2)) begin
      rd2 = wd;
    end
`endif
  end

  assign busy = busy_q;

endmodule
